// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the 8-entry x 8-bit CAM controller:
// geometry constants, command/state encodings and a lowest-set-bit encoder.
package cam_ctrl_pkg;

  localparam int CAM_ENTRIES = 8;
  localparam int CAM_KEY_W   = 8;
  localparam int CAM_IDX_W   = 3;

  typedef enum logic [1:0] {
    CAM_LOOKUP = 2'b00,
    CAM_INSERT = 2'b01,
    CAM_DELETE = 2'b10,
    CAM_FLUSH  = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SEARCH = 2'b01,
    S_WRITE  = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [CAM_IDX_W-1:0] lowest_set(input logic [CAM_ENTRIES-1:0] vec);
    logic [CAM_IDX_W-1:0] idx;
    idx = '0;
    for (int i = CAM_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CAM_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cam_8x8b_1s1w_mem.sv
// CAM storage: 8 x 8-bit entries, one registered write port and one
// combinational search port. Matches are forced low when search is idle.
// Entry valid bits live in the controller, not here.
module cam_8x8b_1s1w_mem
  import cam_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   we_i,
  input  logic [CAM_IDX_W-1:0]   waddr_i,
  input  logic [CAM_KEY_W-1:0]   wdata_i,
  input  logic                   search_en_i,
  input  logic [CAM_KEY_W-1:0]   search_key_i,
  output logic [CAM_ENTRIES-1:0] search_match_o
);

  logic [CAM_KEY_W-1:0] mem_q [CAM_ENTRIES];

  // Write port: a reset edge suppresses any pending write.
  always_ff @(posedge clk_i) begin
    if (!reset_i && we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Search port: per-entry equality compare, gated by search enable.
  always_comb begin
    search_match_o = '0;
    for (int i = 0; i < CAM_ENTRIES; i++) begin
      if (search_en_i) begin
        search_match_o[i] = (mem_q[i] == search_key_i);
      end else begin
        search_match_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl_8x8b.sv
// Sequencing controller for an 8 x 8-bit CAM with val/rdy command and
// response interfaces (LOOKUP / INSERT / DELETE / FLUSH).
// Optional feature macro: CAM_CTRL_STATS_EN enables saturating hit/miss
// counters; without it stat_hits/stat_misses are tied to zero.
module cam_ctrl_8x8b
  import cam_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [1:0]           req_type,
  input  logic [CAM_KEY_W-1:0] req_key,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic                 resp_hit,
  output logic [CAM_IDX_W-1:0] resp_idx,
  output logic [15:0]          stat_hits,
  output logic [15:0]          stat_misses
);

  state_e                 state_q, state_d;
  req_type_e              type_q, type_d;
  logic [CAM_KEY_W-1:0]   key_q, key_d;
  logic [CAM_ENTRIES-1:0] valid_q, valid_d;
  logic [CAM_IDX_W-1:0]   victim_ptr_q, victim_ptr_d;
  logic                   hit_q, hit_d;
  logic [CAM_IDX_W-1:0]   idx_q, idx_d;
  logic                   req_rdy_q, req_rdy_d;
  logic                   resp_val_q, resp_val_d;

  logic                   search_en_s;
  logic                   mem_we_s;
  logic [CAM_ENTRIES-1:0] match_s;
  logic [CAM_ENTRIES-1:0] hit_vec_s;
  logic                   hit_any_s;
  logic [CAM_IDX_W-1:0]   hit_idx_s;
  logic                   free_any_s;
  logic [CAM_IDX_W-1:0]   victim_s;

  cam_8x8b_1s1w_mem u_mem (
    .clk_i          (clk),
    .reset_i        (reset),
    .we_i           (mem_we_s),
    .waddr_i        (victim_s),
    .wdata_i        (key_q),
    .search_en_i    (search_en_s),
    .search_key_i   (key_q),
    .search_match_o (match_s)
  );

  // Only valid entries may hit; lowest index wins. Free entries are preferred as victims.
  always_comb begin
    hit_vec_s  = match_s & valid_q;
    hit_any_s  = |hit_vec_s;
    hit_idx_s  = lowest_set(hit_vec_s);
    free_any_s = ~(&valid_q);
    if (free_any_s) begin
      victim_s = lowest_set(~valid_q);
    end else begin
      victim_s = victim_ptr_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          if (req_type_e'(req_type) == CAM_FLUSH) begin
            state_d = S_RESP;
          end else begin
            state_d = S_SEARCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        if ((type_q == CAM_INSERT) && !hit_any_s) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        if (resp_rdy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: CAM strobes from the current state, handshake flags from the next state.
  always_comb begin
    search_en_s = 1'b0;
    mem_we_s    = 1'b0;
    case (state_q)
      S_SEARCH: search_en_s = 1'b1;
      S_WRITE:  mem_we_s    = 1'b1;
      default: begin
        search_en_s = 1'b0;
        mem_we_s    = 1'b0;
      end
    endcase
    req_rdy_d  = (state_d == S_IDLE);
    resp_val_d = (state_d == S_RESP);
  end

  // Datapath next-state: request latch, valid bits, replacement pointer, result.
  always_comb begin
    type_d       = type_q;
    key_d        = key_q;
    valid_d      = valid_q;
    victim_ptr_d = victim_ptr_q;
    hit_d        = hit_q;
    idx_d        = idx_q;
    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          type_d = req_type_e'(req_type);
          key_d  = req_key;
          if (req_type_e'(req_type) == CAM_FLUSH) begin
            valid_d = '0;
            hit_d   = 1'b0;
            idx_d   = '0;
          end else begin
            valid_d = valid_q;
          end
        end else begin
          type_d = type_q;
        end
      end
      S_SEARCH: begin
        hit_d = hit_any_s;
        idx_d = hit_any_s ? hit_idx_s : {CAM_IDX_W{1'b0}};
        if ((type_q == CAM_DELETE) && hit_any_s) begin
          valid_d[hit_idx_s] = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      S_WRITE: begin
        valid_d[victim_s] = 1'b1;
        hit_d             = 1'b0;
        idx_d             = victim_s;
        if (!free_any_s) begin
          victim_ptr_d = victim_ptr_q + 3'd1;
        end else begin
          victim_ptr_d = victim_ptr_q;
        end
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  // Datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      type_q       <= CAM_LOOKUP;
      key_q        <= '0;
      valid_q      <= '0;
      victim_ptr_q <= '0;
      hit_q        <= 1'b0;
      idx_q        <= '0;
      req_rdy_q    <= 1'b1;
      resp_val_q   <= 1'b0;
    end else begin
      type_q       <= type_d;
      key_q        <= key_d;
      valid_q      <= valid_d;
      victim_ptr_q <= victim_ptr_d;
      hit_q        <= hit_d;
      idx_q        <= idx_d;
      req_rdy_q    <= req_rdy_d;
      resp_val_q   <= resp_val_d;
    end
  end

  assign req_rdy  = req_rdy_q;
  assign resp_val = resp_val_q;
  assign resp_hit = hit_q;
  assign resp_idx = idx_q;

`ifdef CAM_CTRL_STATS_EN
  logic [15:0] hits_q, misses_q;

  // Saturating hit/miss counters, updated when a search completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= 16'h0000;
      misses_q <= 16'h0000;
    end else if (state_q == S_SEARCH) begin
      if (hit_any_s && (hits_q != 16'hFFFF)) begin
        hits_q <= hits_q + 16'h0001;
      end
      if (!hit_any_s && (misses_q != 16'hFFFF)) begin
        misses_q <= misses_q + 16'h0001;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 16'h0000;
  assign stat_misses = 16'h0000;
`endif

endmodule

// File: tb/tb_cam_ctrl_8x8b.sv
// Self-checking bench for cam_ctrl_8x8b: directed sequence plus random
// traffic, checked through an expected-response queue against a simple
// array-based model of the CAM. Honours CAM_CTRL_STATS_EN when defined.
module tb_cam_ctrl_8x8b;

  localparam logic [1:0] T_LOOKUP = 2'b00;
  localparam logic [1:0] T_INSERT = 2'b01;
  localparam logic [1:0] T_DELETE = 2'b10;
  localparam logic [1:0] T_FLUSH  = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_type = 2'b00;
  logic [7:0]  req_key = 8'h00;
  logic        resp_val;
  logic        resp_rdy = 1'b0;
  logic        resp_hit;
  logic [2:0]  resp_idx;
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;

  int nvec = 0;
  int nmis = 0;

  // Reference model: plain arrays of keys/valid flags and a round-robin pointer.
  int mkey [8];
  bit mval [8];
  int mptr;
  int mhits;
  int mmiss;

  // Expected responses {hit, idx}.
  logic [3:0] exp_q [$];

  cam_ctrl_8x8b dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_type    (req_type),
    .req_key     (req_key),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_hit    (resp_hit),
    .resp_idx    (resp_idx),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mval[i] = 1'b0;
    mptr  = 0;
    mhits = 0;
    mmiss = 0;
  endtask

  task automatic model_op(input logic [1:0] t, input logic [7:0] k,
                          output logic h, output logic [2:0] ix, output int lat);
    int hi;
    int fr;
    int v;
    hi = -1;
    for (int i = 0; i < 8; i++)
      if (hi < 0 && mval[i] && mkey[i] == int'(k)) hi = i;
    h = 1'b0; ix = 3'd0; lat = 2;
    case (t)
      T_LOOKUP: begin
        h = (hi >= 0); ix = h ? 3'(hi) : 3'd0; lat = 2;
      end
      T_DELETE: begin
        h = (hi >= 0); ix = h ? 3'(hi) : 3'd0; lat = 2;
        if (h) mval[hi] = 1'b0;
      end
      T_INSERT: begin
        if (hi >= 0) begin
          h = 1'b1; ix = 3'(hi); lat = 2;
        end else begin
          fr = -1;
          for (int i = 0; i < 8; i++) if (fr < 0 && !mval[i]) fr = i;
          if (fr >= 0) v = fr;
          else begin
            v = mptr;
            mptr = (mptr + 1) % 8;
          end
          mkey[v] = int'(k); mval[v] = 1'b1;
          h = 1'b0; ix = 3'(v); lat = 3;
        end
      end
      default: begin
        for (int i = 0; i < 8; i++) mval[i] = 1'b0;
        h = 1'b0; ix = 3'd0; lat = 1;
      end
    endcase
    if (t != T_FLUSH) begin
      if (h) begin if (mhits < 65535) mhits++; end
      else   begin if (mmiss < 65535) mmiss++; end
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef CAM_CTRL_STATS_EN
    chk({tag, "_stat_hits"}, int'(stat_hits), mhits);
    chk({tag, "_stat_misses"}, int'(stat_misses), mmiss);
`else
    chk({tag, "_stat_hits"}, int'(stat_hits), 0);
    chk({tag, "_stat_misses"}, int'(stat_misses), 0);
`endif
  endtask

  // Issue one command, check latency/handshake, optionally stall the response.
  task automatic do_req(input logic [1:0] t, input logic [7:0] k, input int stall);
    logic       h;
    logic [2:0] ix;
    int         lat;
    int         n;
    int         cyc;
    logic       h0;
    logic [2:0] i0;
    n = 0;
    while (!req_rdy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_rdy_wait", int'(req_rdy), 1);
    req_val = 1'b1; req_type = t; req_key = k;
    @(posedge clk); #1;
    req_val = 1'b0;
    model_op(t, k, h, ix, lat);
    exp_q.push_back({h, ix});
    cyc = 1;
    while (!resp_val && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, lat);
    chk("req_rdy_in_resp", int'(req_rdy), 0);
    h0 = resp_hit; i0 = resp_idx;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_resp_val", int'(resp_val), 1);
      chk("stall_hit", int'(resp_hit), int'(h0));
      chk("stall_idx", int'(resp_idx), int'(i0));
      chk("stall_req_rdy", int'(req_rdy), 0);
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    chk("post_resp_val", int'(resp_val), 0);
    chk("post_req_rdy", int'(req_rdy), 1);
    chk_stats("op");
  endtask

  // Monitor: compare each completed response against the scoreboard.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset && resp_val && resp_rdy) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_resp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_hit", int'(resp_hit), int'(e[3]));
        chk("resp_idx", int'(resp_idx), int'(e[2:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [1:0] t;
    model_reset();
    for (int i = 0; i < 8; i++) mkey[i] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_rdy", int'(req_rdy), 1);
    chk("rst_resp_val", int'(resp_val), 0);
    chk("rst_resp_hit", int'(resp_hit), 0);
    chk("rst_resp_idx", int'(resp_idx), 0);
    chk_stats("rst");

    do_req(T_LOOKUP, 8'hA5, 0);
    for (int i = 1; i <= 8; i++) do_req(T_INSERT, 8'(i * 8'h11), 0);
    do_req(T_INSERT, 8'h33, 0);
    do_req(T_INSERT, 8'h99, 0);
    do_req(T_INSERT, 8'hAA, 0);
    do_req(T_LOOKUP, 8'h11, 0);
    do_req(T_DELETE, 8'h44, 0);
    do_req(T_LOOKUP, 8'h44, 0);
    do_req(T_INSERT, 8'hBB, 0);
    do_req(T_LOOKUP, 8'hBB, 5);
    do_req(T_FLUSH, 8'h00, 0);
    do_req(T_LOOKUP, 8'h99, 0);

    // Reset while the controller is in WRITE.
    req_val = 1'b1; req_type = T_INSERT; req_key = 8'h5A;
    @(posedge clk); #1;
    req_val = 1'b0;
    @(posedge clk); #1;
    chk("in_write_req_rdy", int'(req_rdy), 0);
    chk("in_write_resp_val", int'(resp_val), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_write_req_rdy", int'(req_rdy), 1);
    chk("rst_write_resp_val", int'(resp_val), 0);
    chk("rst_write_sb_empty", exp_q.size(), 0);
    chk_stats("rst_write");
    do_req(T_LOOKUP, 8'h5A, 0);
    do_req(T_INSERT, 8'h5A, 1);

    // Random traffic on a small key set so hits, deletes and replacements occur.
    for (int n = 0; n < 200; n++) begin
      r = 4'($urandom_range(0, 15));
      if (r == 4'd0) t = T_FLUSH;
      else t = 2'(r % 4'd3);
      do_req(t, 8'h40 + 8'($urandom_range(0, 11)), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
